// File: rtl/wb_host_pkg.sv
// rtl/wb_host_pkg.sv - shared state type and constants for the Wishbone host master
package wb_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Counter must be able to hold values up to TIMEOUT_CYCLES
    function automatic int timeout_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - Wishbone classic single-transfer initiator with timeout
module wb_host_master
    import wb_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int            CW       = timeout_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    wb_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;
    logic        cmd_ready_q, cmd_ready_d;

    // State and every output are registered; reset drops cyc/stb without waiting for a clock
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            wdat_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    // Next-state and next-output decode; ACK takes priority over the timeout
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    wdat_d  = cmd_dat_i;
                    sel_d   = cmd_sel_i;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_dat_d   = 32'd0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    cyc_d       = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Registered from the next state so it reads 0 while in reset and 1 once running in IDLE
        cmd_ready_d = (state_d == IDLE);
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = wdat_q;

endmodule

// File: tb/tb_wb_host_master.sv
// tb/tb_wb_host_master.sv - self-checking bench for wb_host_master
module tb_wb_host_master;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr, cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_dat;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] sdat;

    wb_host_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_ack_i(ack), .wbm_dat_i(sdat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected view of the current cycle, written by the stimulus/model
    logic        chk_on = 1'b0;
    logic        exp_ready, exp_cyc, exp_valid, exp_err, exp_we;
    logic [31:0] exp_dat, exp_adr, exp_wdat;
    logic [3:0]  exp_sel;

    // Single compare process, mid-cycle
    always @(negedge clk) begin
        if (chk_on) begin
            chk1("cmd_ready", cmd_ready, exp_ready);
            chk1("cyc", cyc, exp_cyc);
            chk1("stb", stb, exp_cyc);
            chk1("rsp_valid", rsp_valid, exp_valid);
            if (exp_cyc) begin
                chk1("bus_we", we, exp_we);
                chk32("bus_adr", adr, exp_adr);
                chk32("bus_wdat", wdat, exp_wdat);
                chk32("bus_sel", {28'd0, sel}, {28'd0, exp_sel});
            end
            if (exp_valid) begin
                chk32("rsp_dat", rsp_dat, exp_dat);
                chk1("rsp_err", rsp_err, exp_err);
            end
        end
    end

    // Passive monitor measuring strobe length, latency and first response values
    int          cyc_no = 0, hs_cyc = 0, last_lat = 0;
    int          stb_run = 0, last_stb_len = 0, valid_run = 0, last_valid_len = 0;
    logic [31:0] first_dat = '0;
    logic        first_err = 1'b0;
    always @(negedge clk) begin
        cyc_no++;
        if (cmd_valid && cmd_ready) hs_cyc = cyc_no;
        if (stb) stb_run++;
        else if (stb_run != 0) begin last_stb_len = stb_run; stb_run = 0; end
        if (rsp_valid) begin
            if (valid_run == 0) begin
                last_lat  = cyc_no - hs_cyc;
                first_dat = rsp_dat;
                first_err = rsp_err;
            end
            valid_run++;
        end else if (valid_run != 0) begin
            last_valid_len = valid_run;
            valid_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle_exp();
        exp_ready = 1'b1;
        exp_cyc   = 1'b0;
        exp_valid = 1'b0;
    endtask

    // Idle cycles with stray ACKs that must be ignored
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cmd_valid = 1'b0;
            rsp_ready = 1'b0;
            ack       = 1'($urandom_range(0, 1));
            sdat      = $urandom;
            tick();
            set_idle_exp();
        end
    endtask

    // One transfer; the expected timeline follows from the protocol rules:
    // slave acks in strobe cycle ws+1, which only counts if it is within T cycles.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int ws, input logic [31:0] rd,
                        input int rdelay);
        logic        to;
        int          nstb;
        logic [31:0] edat;
        to   = (ws >= T);
        nstb = to ? T : ws + 1;
        edat = (w || to) ? 32'd0 : rd;

        cmd_valid = 1'b1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s;
        rsp_ready = 1'($urandom_range(0, 1));
        tick();
        exp_we = w; exp_adr = a; exp_wdat = d; exp_sel = s;
        for (int i = 1; i <= nstb; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_we = 1'($urandom_range(0, 1)); cmd_adr = $urandom; cmd_dat = $urandom;
            cmd_sel = 4'($urandom);
            rsp_ready = 1'($urandom_range(0, 1));
            exp_ready = 1'b0; exp_cyc = 1'b1; exp_valid = 1'b0;
            ack  = (i == ws + 1);
            sdat = (i == ws + 1) ? rd : $urandom;
            tick();
        end
        exp_cyc = 1'b0; exp_ready = 1'b0; exp_valid = 1'b1;
        exp_dat = edat; exp_err = to;
        for (int i = 0; i <= rdelay; i++) begin
            rsp_ready = (i == rdelay);
            cmd_valid = 1'($urandom_range(0, 1));
            ack  = 1'($urandom_range(0, 1));
            sdat = $urandom;
            tick();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        set_idle_exp();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
        cmd_sel = '0; rsp_ready = 1'b0; ack = 1'b0; sdat = '0;
        exp_we = 1'b0; exp_adr = '0; exp_wdat = '0; exp_sel = '0; exp_dat = '0; exp_err = 1'b0;
        set_idle_exp();

        repeat (2) @(posedge clk);
        #3;
        chk1("reset_outputs_zero",
             |{cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, stb, we, sel, adr, wdat}, 1'b0);
        rst_n = 1'b1;
        #1;
        chk1("ready_before_first_edge", cmd_ready, 1'b0);
        tick();
        #1;
        chk1("ready_after_release", cmd_ready, 1'b1);
        set_idle_exp();
        chk_on = 1'b1;

        // Write, ACK in the first strobe cycle
        xfer(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 0);
        idle(1);
        chk32("wr_latency", last_lat, 32'd2);
        chk32("wr_stb_len", last_stb_len, 32'd1);
        chk32("wr_rsp_dat", first_dat, 32'd0);
        chk1("wr_rsp_err", first_err, 1'b0);

        // Read with 3 wait states: ACK lands on the last timeout cycle
        xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 3, 32'hCAFE_F00D, 0);
        idle(1);
        chk32("rd3_stb_len", last_stb_len, 32'd4);
        chk32("rd3_rsp_dat", first_dat, 32'hCAFE_F00D);
        chk1("rd3_rsp_err", first_err, 1'b0);

        // Slave never ACKs
        xfer(1'b0, 32'h3000_0010, 32'h0, 4'h3, 1000, 32'hDEAD_BEEF, 0);
        idle(1);
        chk32("to_stb_len", last_stb_len, 32'd4);
        chk32("to_latency", last_lat, 32'd5);
        chk32("to_rsp_dat", first_dat, 32'd0);
        chk1("to_rsp_err", first_err, 1'b1);

        // Normal read after a timeout
        xfer(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 32'h1234_5678, 0);
        idle(1);
        chk32("post_to_rsp_dat", first_dat, 32'h1234_5678);
        chk1("post_to_rsp_err", first_err, 1'b0);
        chk32("post_to_stb_len", last_stb_len, 32'd2);

        // Response held off for 10 cycles
        xfer(1'b0, 32'h3000_0018, 32'h0, 4'hC, 2, 32'h0BAD_F00D, 10);
        idle(1);
        chk32("hold_valid_len", last_valid_len, 32'd11);

        // Randomized traffic including back-to-back commands
        for (int n = 0; n < 150; n++) begin
            xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom),
                 int'($urandom_range(0, T + 2)), $urandom, int'($urandom_range(0, 3)));
            idle(int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a bus cycle
        chk_on = 1'b0;
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0020; cmd_sel = 4'hF;
        ack = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        #1;
        chk1("bus_before_reset", cyc, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("async_rst_cyc", cyc, 1'b0);
        chk1("async_rst_stb", stb, 1'b0);
        chk1("async_rst_all_zero",
             |{cmd_ready, rsp_valid, rsp_dat, rsp_err, cyc, stb, we, sel, adr, wdat}, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        chk1("ready_after_mid_reset", cmd_ready, 1'b1);
        ack = 1'b1; sdat = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk1("stray_ack_no_rsp", rsp_valid, 1'b0);
            chk1("stray_ack_no_cyc", cyc, 1'b0);
        end
        ack = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer initiator: the initiating end of the WB MI A slave port that the user project exposes. It accepts read and write commands on a valid/ready command channel, runs one Wishbone cycle per command, and returns read data or a timeout error on a valid/ready response channel. It is used as the on-chip bus master in front of the user-project slave, in test harnesses, and for LA/GPIO-driven bring-up paths.

## Interface
- TIMEOUT_CYCLES, 255: cycles STB may stay high without ACK before the transfer is aborted; range 1..65535.
- wb_clk_i  in  1  single clock, rising edge.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when both valid and ready are high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte lanes.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when both valid and ready are high.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  transfer timed out.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls.
- wbm_sel_o  out  4  Wishbone byte lanes.
- wbm_adr_o, wbm_dat_o  out  32 each  Wishbone address and write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, register we/adr/dat/sel into the wbm_* outputs, set cyc and stb, clear the timeout counter, and go to BUS.
- BUS:
  - cyc and stb held high; adr/dat/sel/we stable.
  - Timeout counter increments each cycle without ACK.
  - On wbm_ack_i = 1:
    - capture wbm_dat_i into rsp_dat_o if read, else 0;
    - set rsp_err_o = 0 and rsp_valid_o = 1;
    - clear cyc and stb; go to RESP.
  - If the counter reaches TIMEOUT_CYCLES-1 with no ACK:
    - clear cyc and stb;
    - set rsp_dat_o = 0, rsp_err_o = 1, rsp_valid_o = 1; go to RESP.
  - ACK and timeout in the same cycle: ACK wins, err = 0.
- RESP:
  - rsp_* held stable until rsp_ready_i = 1, then rsp_valid_o clears and the FSM goes to IDLE.
  - cmd_ready_o = 0.
- ACK outside BUS is ignored.
- wbm_cyc_o always equals wbm_stb_o; no back-to-back or burst cycles.
- rsp_dat_o is 0 on writes.
- Reset: all outputs are 0 (cmd_ready_o = 0 during reset, 1 from the first cycle after release), and the FSM is in IDLE. Reset asserted mid-BUS drops cyc/stb immediately (asynchronously); the in-flight response is lost.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs except none: cmd_ready_o is decoded from state only.
- Command handshake at edge N → cyc/stb high from N+1.
- ACK sampled at edge M → cyc/stb low and rsp_valid_o high from M+1.
- Minimum command-to-response latency is 2 cycles (ACK in the first STB cycle).
- Throughput: one transfer every 3 cycles best case (IDLE, BUS, RESP with rsp_ready_i held high).
- Timeout: STB is high for exactly TIMEOUT_CYCLES cycles, then rsp_valid_o with err on the next cycle.
- The next command is accepted no earlier than the cycle after the response handshake.

## Structure
- Package wb_host_pkg holds:
  - the state enum (IDLE, BUS, RESP);
  - the default timeout constant;
  - the timeout-counter width function ($clog2(TIMEOUT_CYCLES+1)).
- Single module; no sub-module. The timeout counter is small enough to stay inline.

## Test plan
- Write 0x3000_0004 ← 0xA5A5_1234, sel 0xF, slave ACKs on the first STB cycle:
  - bus shows we = 1 with the same adr/dat/sel;
  - rsp_valid_o rises 2 cycles after the command handshake with dat = 0, err = 0.
- Read 0x3000_0008, slave returns 0xCAFE_F00D with 3 wait states:
  - stb is high for 4 cycles;
  - rsp_dat_o = 0xCAFE_F00D, err = 0.
- TIMEOUT_CYCLES = 4, slave never ACKs:
  - stb is high for exactly 4 cycles;
  - rsp_err_o = 1, rsp_dat_o = 0;
  - a subsequent normal read succeeds.
- ACK arrives on the last timeout cycle → err = 0 and the data is captured.
- rsp_ready_i held low for 10 cycles:
  - rsp_* stay stable;
  - cmd_ready_o stays 0 and cyc stays 0.
- wb_rst_n_i asserted during BUS:
  - cyc/stb go low immediately and all outputs become 0;
  - after release cmd_ready_o = 1, and a stray ACK is ignored with no response generated.
